// File: rtl/audiodac_fifo.sv
// audiodac_fifo: 16b sample FIFO feeding the delta-sigma modulator; reports fill level, low-water and sticky under/overrun status
module audiodac_fifo #(
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5,
  parameter int LOW_WATER = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [15:0]       wr_data_i,
  input  logic              wr_en_i,
  input  logic              rd_i,
  output logic [15:0]       data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              low_o,
  output logic              underrun_o,
  output logic              overrun_o,
  input  logic              clr_flags_i
);
  localparam logic [ADDR_W:0] LW = (ADDR_W+1)'(LOW_WATER);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] MSB = {1'b1, {ADDR_W{1'b0}}};
  logic [15:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign level_o = wr_ptr - rd_ptr;
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o = (wr_ptr ^ rd_ptr) == MSB;
  assign low_o = level_o <= LW;
  assign do_pop = rd_i & ~empty_o;
  assign do_push = wr_en_i & (~full_o | do_pop);
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i;
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_o <= '0;
      underrun_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + ONE : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + ONE : rd_ptr;
      data_o <= do_pop ? mem[rd_ptr[ADDR_W-1:0]] : data_o;
      underrun_o <= (rd_i & empty_o) | (underrun_o & ~clr_flags_i);
      overrun_o <= (wr_en_i & full_o & ~rd_i) | (overrun_o & ~clr_flags_i);
    end
endmodule

// File: tb/tb_audiodac_fifo.sv
// tb_audiodac_fifo: scoreboard bench for audiodac_fifo
module tb_audiodac_fifo;
  localparam int DEPTH = 32;
  localparam int LOW_WATER = 8;
  logic clk = 0, rst_n = 0, wr_en = 0, rd = 0, clr = 0;
  logic [15:0] wr_data = 0, data;
  logic full, empty, low, under, over;
  logic [5:0] level;
  logic rd_seen = 0;
  logic [15:0] exp_q[$];
  int cmp = 0, err = 0;
  audiodac_fifo #(.DEPTH(DEPTH), .ADDR_W(5), .LOW_WATER(LOW_WATER)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_data_i(wr_data), .wr_en_i(wr_en), .rd_i(rd),
    .data_o(data), .full_o(full), .empty_o(empty), .level_o(level), .low_o(low),
    .underrun_o(under), .overrun_o(over), .clr_flags_i(clr));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(posedge clk) rd_seen <= rd & rst_n;
  always @(negedge clk)
    if (rd_seen) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("data_o", {16'h0, data}, {16'h0, exp_q.pop_front()});
    end
  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic [15:0] e, input logic c);
    @(negedge clk);
    wr_en = w; wr_data = d; rd = r; clr = c;
    if (r) exp_q.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 0; rd = 0; clr = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_low", low, 1); chk("rst_under", under, 0); chk("rst_over", over, 0);
    chk("rst_data", data, 0);
    @(negedge clk); rst_n = 1;
    step(1, 16'h1111, 0, 0, 0); step(1, 16'h2222, 0, 0, 0); step(1, 16'h3333, 0, 0, 0);
    chk("t1_level3", level, 3); chk("t1_empty", empty, 0);
    step(0, 0, 1, 16'h1111, 0);
    chk("t1_level2", level, 2);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    chk("t1_hold", data, 16'h1111);
    step(0, 0, 1, 16'h2222, 0); step(0, 0, 1, 16'h3333, 0);
    step(1, 16'h1234, 0, 0, 0); step(0, 0, 1, 16'h1234, 0);
    chk("t3_empty", empty, 1);
    step(0, 0, 1, 16'h1234, 1);
    chk("t3_under_set_wins", under, 1); chk("t3_level", level, 0); chk("t3_data", data, 16'h1234);
    step(0, 0, 0, 0, 1);
    chk("t3_under_clr", under, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
    chk("t2_full", full, 1); chk("t2_over0", over, 0); chk("t2_low", low, 0);
    step(1, 16'hDEAD, 0, 0, 0);
    chk("t2_over", over, 1); chk("t2_level", level, DEPTH);
    step(0, 0, 0, 0, 1);
    chk("t2_over_clr", over, 0);
    step(1, 16'hBEEF, 1, 16'h0100, 0);
    chk("t4_level", level, DEPTH); chk("t4_over", over, 0); chk("t4_full", full, 1);
    for (int i = 1; i < DEPTH; i++) step(0, 0, 1, 16'h0100 + 16'(i), 0);
    step(0, 0, 1, 16'hBEEF, 0);
    chk("t4_drained", empty, 1);
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1, 16'h2000 + 16'(i), i >= 4, 16'h2000 + 16'(i) - 16'd4, 0);
    chk("t4_wrap_level", level, 4);
    for (int i = 3 * DEPTH - 4; i < 3 * DEPTH; i++) step(0, 0, 1, 16'h2000 + 16'(i), 0);
    chk("t4_no_under", under, 0); chk("t4_empty", empty, 1);
    step(1, 16'h5555, 1, 16'h205F, 0);
    chk("t5_under", under, 1); chk("t5_level", level, 1);
    step(0, 0, 1, 16'h5555, 1);
    chk("t5_data", data, 16'h5555);
    for (int i = 0; i < LOW_WATER; i++) step(1, 16'h3000 + 16'(i), 0, 0, 0);
    chk("t6_low_at_lw", low, 1);
    step(1, 16'h3000 + 16'(LOW_WATER), 0, 0, 0);
    chk("t6_low0", low, 0); chk("t6_level", level, LOW_WATER + 1);
    step(0, 0, 1, 16'h3000, 0);
    chk("t6_low1", low, 1);
    for (int i = 0; i < 8; i++) step(1, 16'h4000 + 16'(i), 0, 0, 0);
    chk("t6_half", level, 16);
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1;
    chk("t6_rst_level", level, 0); chk("t6_rst_empty", empty, 1); chk("t6_rst_full", full, 0);
    chk("t6_rst_low", low, 1); chk("t6_rst_under", under, 0); chk("t6_rst_over", over, 0);
    chk("t6_rst_data", data, 0);
    @(negedge clk); rst_n = 1;
    step(1, 16'h7777, 0, 0, 0);
    chk("fresh_level", level, 1);
    step(0, 0, 1, 16'h7777, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
